// File: rtl/ddr2_pkt_checker_if.sv
// Packet bus for the DDR2 packet checker: expected-packet push side, observed-packet
// strobe side and the registered compare result.
interface ddr2_pkt_checker_if;
   logic         exp_valid;
   logic         exp_ready;
   logic [2:0]   exp_cmd;
   logic [1:0]   exp_bank;
   logic [12:0]  exp_row;
   logic [9:0]   exp_col;
   logic [127:0] exp_data;

   logic         obs_valid;
   logic [2:0]   obs_cmd;
   logic [1:0]   obs_bank;
   logic [12:0]  obs_row;
   logic [9:0]   obs_col;
   logic [127:0] obs_data;
   logic [31:0]  obs_id;

   logic         cmp_valid;
   logic         cmp_pass;
   logic [31:0]  cmp_id;

   modport master (
      output exp_valid, exp_cmd, exp_bank, exp_row, exp_col, exp_data,
      output obs_valid, obs_cmd, obs_bank, obs_row, obs_col, obs_data, obs_id,
      input  exp_ready, cmp_valid, cmp_pass, cmp_id
   );

   modport slave (
      input  exp_valid, exp_cmd, exp_bank, exp_row, exp_col, exp_data,
      input  obs_valid, obs_cmd, obs_bank, obs_row, obs_col, obs_data, obs_id,
      output exp_ready, cmp_valid, cmp_pass, cmp_id
   );
endinterface

// File: rtl/ddr2_pkt_checker.sv
// In-order DDR2 packet checker: expected packets queue in a FIFO, each observed packet
// is compared against the head. Define DDR2_CHK_TIMEOUT_EN to enable the head watchdog.
//
// state     | meaning
// S_IDLE    | FIFO empty, nothing awaited
// S_ARMED   | FIFO holds packets, waiting for observed traffic
// S_STALLED | head waited TIMEOUT cycles; head retained until next pop
module ddr2_pkt_checker #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024,
   parameter int DEBUG   = 0
) (
   input  logic                ck,
   input  logic                reset_n,
   ddr2_pkt_checker_if.slave   bus,
   output logic [15:0]         match_cnt,
   output logic [15:0]         mismatch_cnt,
   output logic [7:0]          unexpected_cnt,
   output logic                err,
   output logic                timeout
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = 3 + 2 + 13 + 10 + 128;

   if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || DEBUG < 0)
   begin : g_param_err
      $error("ddr2_pkt_checker: unsupported parameter value");
   end

`ifdef DDR2_CHK_TIMEOUT_EN
   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_STALLED} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ARMED} state_t;
`endif

   state_t          state, state_next;
   logic [PW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            full, empty, push, pop, unexpected, same_pkt;
   logic [PW-1:0]   head, obs_pkt;

   assign full       = (count == (AW+1)'(DEPTH));
   assign empty      = (count == '0);
   assign pop        = bus.obs_valid && !empty;
   assign unexpected = bus.obs_valid && empty;
   // a pop frees the slot in the same cycle, so a full FIFO still takes the push
   assign push       = bus.exp_valid && (!full || pop);
   assign bus.exp_ready = !full;
   assign head       = mem[rd_ptr];
   assign obs_pkt    = {bus.obs_cmd, bus.obs_bank, bus.obs_row, bus.obs_col, bus.obs_data};
   assign same_pkt   = (head == obs_pkt);

   always_ff @(posedge ck) begin
      if (push)
         mem[wr_ptr] <= {bus.exp_cmd, bus.exp_bank, bus.exp_row, bus.exp_col, bus.exp_data};
   end

`ifdef DDR2_CHK_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wait_cnt;
   logic          timeout_q;
   logic          stall_enter;

   assign stall_enter = (state == S_ARMED) && (state_next == S_STALLED);
   assign timeout     = timeout_q;

   always_ff @(posedge ck) begin
      if (!reset_n) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (pop || state == S_IDLE)
            wait_cnt <= '0;
         else if (state == S_ARMED && !bus.obs_valid && wait_cnt != WW'(TIMEOUT))
            wait_cnt <= wait_cnt + WW'(1);
         if (stall_enter)
            timeout_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge ck) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:
            if (push) state_next = S_ARMED;
         S_ARMED:
            if (pop && !push && count == (AW+1)'(1))
               state_next = S_IDLE;
`ifdef DDR2_CHK_TIMEOUT_EN
            else if (!bus.obs_valid && wait_cnt == WW'(TIMEOUT))
               state_next = S_STALLED;
         S_STALLED:
            if (pop)
               state_next = (!push && count == (AW+1)'(1)) ? S_IDLE : S_ARMED;
`endif
         default:
            state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ck) begin
      if (!reset_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         bus.cmp_valid  <= 1'b0;
         bus.cmp_pass   <= 1'b0;
         bus.cmp_id     <= '0;
         match_cnt      <= '0;
         mismatch_cnt   <= '0;
         unexpected_cnt <= '0;
         err            <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count         <= count + (AW+1)'(push) - (AW+1)'(pop);
         bus.cmp_valid <= pop;
         if (pop) begin
            bus.cmp_pass <= same_pkt;
            bus.cmp_id   <= bus.obs_id;
            if (same_pkt) begin
               if (match_cnt != '1) match_cnt <= match_cnt + 16'd1;
            end else begin
               if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 16'd1;
               err <= 1'b1;
            end
         end
         if (unexpected) begin
            if (unexpected_cnt != '1) unexpected_cnt <= unexpected_cnt + 8'd1;
            err <= 1'b1;
         end
`ifdef DDR2_CHK_TIMEOUT_EN
         if (stall_enter) err <= 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_ddr2_pkt_checker.sv
// Directed bench for ddr2_pkt_checker with a packet-queue model and result scoreboard.
module tb_ddr2_pkt_checker;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [2:0]   cmd;
      logic [1:0]   bank;
      logic [12:0]  row;
      logic [9:0]   col;
      logic [127:0] data;
   } pkt_t;

   logic        ck = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] match_cnt, mismatch_cnt;
   logic [7:0]  unexpected_cnt;
   logic        err, timeout;
   logic [31:0] cyc = 0;

   ddr2_pkt_checker_if bus();

   ddr2_pkt_checker #(.DEPTH(DEPTH), .TIMEOUT(16), .DEBUG(0)) dut (
      .ck             (ck),
      .reset_n        (reset_n),
      .bus            (bus.slave),
      .match_cnt      (match_cnt),
      .mismatch_cnt   (mismatch_cnt),
      .unexpected_cnt (unexpected_cnt),
      .err            (err),
      .timeout        (timeout)
   );

   always #5 ck = ~ck;
   always @(posedge ck) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   pkt_t        mfifo[$];
   logic        sb_pass[$];
   logic [31:0] sb_id[$];
   logic [31:0] sb_due[$];
   int          m_match = 0, m_mismatch = 0, m_unexp = 0;
   logic        m_err = 1'b0, m_to = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      assert (got === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   always @(negedge ck) begin
      if (bus.cmp_valid === 1'b1) begin
         if (sb_pass.size() == 0) begin
            chk("cmp_spurious", 32'(bus.cmp_valid), 32'd0);
         end else begin
            chk("cmp_pass", 32'(bus.cmp_pass), 32'(sb_pass.pop_front()));
            chk("cmp_id", bus.cmp_id, sb_id.pop_front());
            chk("cmp_latency", cyc, sb_due.pop_front());
         end
      end
   end

   function automatic pkt_t mk(input logic [2:0] c, input logic [1:0] b, input logic [12:0] r,
                               input logic [9:0] co, input logic [127:0] d);
      pkt_t p;
      p.cmd = c; p.bank = b; p.row = r; p.col = co; p.data = d;
      return p;
   endfunction

   task automatic step(input logic push, input pkt_t ep, input logic obs, input pkt_t op,
                       input logic [31:0] id);
      logic full_b;
      logic ok;
      pkt_t h;
      full_b = (mfifo.size() == DEPTH);
      chk("exp_ready", 32'(bus.exp_ready), 32'(!full_b));
      bus.exp_valid = push;
      {bus.exp_cmd, bus.exp_bank, bus.exp_row, bus.exp_col, bus.exp_data} = ep;
      bus.obs_valid = obs;
      {bus.obs_cmd, bus.obs_bank, bus.obs_row, bus.obs_col, bus.obs_data} = op;
      bus.obs_id = id;
      if (obs) begin
         if (mfifo.size() == 0) begin
            if (m_unexp != 255) m_unexp++;
            m_err = 1'b1;
         end else begin
            h  = mfifo.pop_front();
            ok = (h == op);
            sb_pass.push_back(ok);
            sb_id.push_back(id);
            sb_due.push_back(cyc + 1);
            if (ok) begin
               if (m_match != 65535) m_match++;
            end else begin
               if (m_mismatch != 65535) m_mismatch++;
               m_err = 1'b1;
            end
         end
      end
      if (push && (!full_b || obs)) mfifo.push_back(ep);
      @(posedge ck);
      #1;
      bus.exp_valid = 1'b0;
      bus.obs_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      pkt_t z;
      z = '0;
      for (int i = 0; i < n; i++) step(1'b0, z, 1'b0, z, 32'd0);
   endtask

   task automatic do_reset(input logic with_obs, input pkt_t op);
      reset_n = 1'b0;
      bus.obs_valid = with_obs;
      {bus.obs_cmd, bus.obs_bank, bus.obs_row, bus.obs_col, bus.obs_data} = op;
      bus.obs_id = 32'hDEAD_0001;
      @(posedge ck);
      #1;
      reset_n = 1'b1;
      bus.obs_valid = 1'b0;
      mfifo.delete();
      sb_pass.delete(); sb_id.delete(); sb_due.delete();
      m_match = 0; m_mismatch = 0; m_unexp = 0; m_err = 1'b0; m_to = 1'b0;
   endtask

   task automatic chk_outs(input string t);
      @(negedge ck);
      chk({t, ":match_cnt"}, 32'(match_cnt), 32'(m_match));
      chk({t, ":mismatch_cnt"}, 32'(mismatch_cnt), 32'(m_mismatch));
      chk({t, ":unexpected_cnt"}, 32'(unexpected_cnt), 32'(m_unexp));
      chk({t, ":err"}, 32'(err), 32'(m_err));
      chk({t, ":timeout"}, 32'(timeout), 32'(m_to));
      chk({t, ":exp_ready"}, 32'(bus.exp_ready), 32'(mfifo.size() != DEPTH));
   endtask

   task automatic chk_reset_outs(input string t);
      chk_outs(t);
      chk({t, ":cmp_valid"}, 32'(bus.cmp_valid), 32'd0);
      chk({t, ":cmp_pass"}, 32'(bus.cmp_pass), 32'd0);
      chk({t, ":cmp_id"}, bus.cmp_id, 32'd0);
   endtask

   initial begin
      pkt_t z, pw, pr, pbad, pa, pb;
      pkt_t q[DEPTH + 1];
      z = '0;
      bus.exp_valid = 1'b0; bus.obs_valid = 1'b0; bus.obs_id = '0;
      {bus.exp_cmd, bus.exp_bank, bus.exp_row, bus.exp_col, bus.exp_data} = z;
      {bus.obs_cmd, bus.obs_bank, bus.obs_row, bus.obs_col, bus.obs_data} = z;
      repeat (2) @(posedge ck);
      #1;
      reset_n = 1'b1;
      chk_reset_outs("reset");

      // single matching WRITE
      pw = mk(3'd2, 2'd2, 13'h0A5, 10'h010,
              {16'h8, 16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1});
      step(1'b1, pw, 1'b0, z, 32'd0);
      step(1'b0, z, 1'b1, pw, 32'h0000_0100);
      chk_outs("write_match");

      // READ with beat 7 bit 0 flipped; err must stay sticky
      pr = mk(3'd1, 2'd1, 13'h1234, 10'h3FF, {8{16'hA5C3}});
      pbad = pr;
      pbad.data[112] = ~pbad.data[112];
      step(1'b1, pr, 1'b0, z, 32'd0);
      step(1'b0, z, 1'b1, pbad, 32'h0000_0101);
      chk_outs("read_mismatch");
      idle(5);
      chk_outs("err_sticky");

      // unexpected on empty FIFO, then push+obs together on empty
      do_reset(1'b0, z);
      step(1'b0, z, 1'b1, pw, 32'h0000_0200);
      chk_outs("unexpected");
      step(1'b1, pr, 1'b1, pr, 32'h0000_0201);
      chk_outs("push_obs_empty");
      step(1'b0, z, 1'b1, pr, 32'h0000_0202);
      chk_outs("stored_after_unexp");

      // fill to DEPTH, push+pop while full, drain in order
      do_reset(1'b0, z);
      for (int i = 0; i <= DEPTH; i++)
         q[i] = mk(3'(1 + (i % 2)), 2'(i), 13'($urandom), 10'($urandom),
                   {$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < DEPTH; i++) step(1'b1, q[i], 1'b0, z, 32'd0);
      chk_outs("full");
      step(1'b1, q[DEPTH], 1'b1, q[0], 32'h0000_0300);
      chk_outs("full_push_pop");
      for (int i = 1; i <= DEPTH; i++) step(1'b0, z, 1'b1, q[i], 32'h0000_0300 + 32'(i));
      chk_outs("drained");

      // watchdog
      do_reset(1'b0, z);
      step(1'b1, pw, 1'b0, z, 32'd0);
      idle(10);
      chk_outs("wait_short");
      idle(20);
`ifdef DDR2_CHK_TIMEOUT_EN
      m_to = 1'b1;
      m_err = 1'b1;
`endif
      chk_outs("wait_long");
      step(1'b0, z, 1'b1, pw, 32'h0000_0400);
      step(1'b1, pr, 1'b0, z, 32'd0);
      step(1'b0, z, 1'b1, pr, 32'h0000_0401);
      chk_outs("after_stall");

      // unexpected_cnt saturation
      do_reset(1'b0, z);
      for (int i = 0; i < 260; i++) step(1'b0, z, 1'b1, pw, 32'(i));
      chk_outs("unexp_sat");

      // mismatch_cnt saturation with one packet in flight each cycle
      do_reset(1'b0, z);
      pa = pw;
      pb = pw;
      pb.data = ~pw.data;
      step(1'b1, pa, 1'b0, z, 32'd0);
      for (int i = 0; i < 65536; i++) step(1'b1, pa, 1'b1, pb, 32'(i));
      chk_outs("mismatch_sat");
      step(1'b1, pr, 1'b1, pa, 32'h0000_0500);
      do_reset(1'b1, pr);
      chk_reset_outs("mid_reset");
      step(1'b0, z, 1'b1, pr, 32'h0000_0600);
      chk_outs("fifo_discarded");

      chk("sb_drained", 32'(sb_pass.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/ddr2_pkt_checker.md
DDR2_PKT_CHECKER -- requirements
Module: ddr2_pkt_checker

Interface
REQ-001 Parameter DEPTH, default 8, expected-packet FIFO depth (power of 2, 2..64).
REQ-002 Parameter TIMEOUT, default 1024, max cycles the FIFO head may wait for an observed packet.
REQ-003 Parameter DEBUG, default 0, nonzero enables $display of every compare result.
REQ-004 ck  in  1  clock; all logic on posedge ck.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 exp_valid  in  1  expected packet (from command generator) offered.
REQ-007 exp_ready  out  1  FIFO can accept; high when not full.
REQ-008 exp_cmd  in  3  1=READ, 2=WRITE; exp_bank in 2; exp_row in 13; exp_col in 10; exp_data in 128 (8 beats x 16, beat 0 in [15:0]).
REQ-009 obs_valid  in  1  single-cycle strobe, observed packet from DDR2 interface monitor; no backpressure.
REQ-010 obs_cmd in 3, obs_bank in 2, obs_row in 13, obs_col in 10, obs_data in 128, obs_id in 32: observed packet fields, same encoding as expected.
REQ-011 cmp_valid  out  1  one-cycle pulse, compare result valid.
REQ-012 cmp_pass  out  1  result of that compare; valid only with cmp_valid.
REQ-013 cmp_id  out  32  obs_id of the compared packet.
REQ-014 match_cnt out 16, mismatch_cnt out 16, unexpected_cnt out 8: saturating counters.
REQ-015 err  out  1  sticky: any mismatch, unexpected, or timeout.
REQ-016 timeout  out  1  sticky watchdog flag.

Function
REQ-017 Push: exp_valid && exp_ready writes all exp_* fields into FIFO tail in that cycle.
REQ-018 obs_valid with FIFO non-empty pops head same cycle; compare registered; cmp_valid/cmp_pass/cmp_id appear exactly 1 cycle after obs_valid.
REQ-019 Pass iff cmd, bank, row, col and all 128 data bits equal; match_cnt or mismatch_cnt increments with cmp_valid.
REQ-020 obs_valid with FIFO empty (after same-cycle push considered absent): no pop, unexpected_cnt+1, err set next cycle, cmp_valid stays low.
REQ-021 Simultaneous push and pop when full: both occur, occupancy unchanged; exp_ready still low that cycle (no bypass).
REQ-022 Simultaneous push and pop when empty: push stored, obs treated as unexpected (REQ-020).
REQ-023 Pointers wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1; exp_ready = (count != DEPTH).
REQ-024 State machine: IDLE (FIFO empty) -> ARMED on push; ARMED -> IDLE when pop empties FIFO with no push; ARMED -> STALLED when wait counter reaches TIMEOUT; STALLED -> ARMED on next pop; STALLED retains head.
REQ-025 Wait counter clears on every pop and in IDLE, increments each ARMED cycle without obs_valid.
REQ-026 Counters saturate at all-ones, never wrap.
REQ-027 Any new obs_valid while previous compare registers are outputting is accepted (back-to-back obs every cycle supported).

Reset
REQ-028 reset_n low at posedge ck: FIFO empty, state IDLE, wait counter 0, all counters 0, err=0, timeout=0, cmp_valid=0, cmp_pass=0, cmp_id=0; exp_ready=1 first cycle after reset.
REQ-029 Reset mid-operation discards FIFO contents and any pending compare; no cmp_valid in the cycle after reset.

Configuration
REQ-030 Macro DDR2_CHK_TIMEOUT_EN defined: watchdog, STALLED state, and timeout output active per REQ-024/025; timeout=1 sets err.
REQ-031 Macro undefined: no wait counter, no STALLED state, timeout tied 0; ARMED holds indefinitely.

Verification
REQ-032 Push 1 WRITE (bank 2, row 0x0A5, col 0x010, data 0x0001..0x0008), then matching obs -> cmp_valid 1 cycle later, cmp_pass=1, match_cnt=1, err=0.
REQ-033 Push READ, obs with data beat 7 bit 0 flipped -> cmp_pass=0, mismatch_cnt=1, err=1 and stays 1 until reset.
REQ-034 obs_valid with FIFO empty -> unexpected_cnt=1, no cmp_valid, err=1.
REQ-035 Push 8 packets (DEPTH=8) -> exp_ready=0; push+obs same cycle -> count stays 8, in-order compares for all 9 pass.
REQ-036 With DDR2_CHK_TIMEOUT_EN, TIMEOUT=16: push 1, no obs for 16 cycles -> timeout=1, err=1; later obs -> compare proceeds, state ARMED/IDLE; without macro timeout stays 0.
REQ-037 Force mismatch_cnt to 0xFFFF via 65535 mismatches (or preload in sim), one more -> stays 0xFFFF; assert reset_n low mid-stream -> all outputs at REQ-028 values next cycle.
